// File: rtl/layer_activation_stack.sv
// Activation stack for a forward/backward training pipeline.
// The forward pass pushes one M x N activation matrix per layer and the backward
// pass pops them in reverse order. Each matrix is one atomic entry. The top entry
// is always visible on pop_data with no read latency, and pop_data is zero when
// the stack is empty.
module layer_activation_stack #(
  parameter int M            = 2,
  parameter int N            = 1,
  parameter int TOTAL_LAYERS = 3,
  parameter int DATA_W       = 8,
  localparam int CW = $clog2(TOTAL_LAYERS + 1),
  localparam int TW = (TOTAL_LAYERS > 1) ? $clog2(TOTAL_LAYERS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push_valid,
  output logic                             push_ready,
  input  logic [0:M-1][0:N-1][DATA_W-1:0]  push_data,
  output logic                             pop_valid,
  input  logic                             pop_ready,
  output logic [0:M-1][0:N-1][DATA_W-1:0]  pop_data,
  input  logic                             flush,
  output logic [CW-1:0]                    count,
  output logic [TW-1:0]                    top_layer,
  output logic                             full,
  output logic                             empty,
  output logic                             err_overflow,
  output logic                             err_underflow
);

  logic [0:M-1][0:N-1][DATA_W-1:0] mem_reg [TOTAL_LAYERS];
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          ovf_reg;
  logic          unf_reg;

  logic          push_fire;
  logic          pop_fire;
  logic          wr_en;
  logic [CW-1:0] top_idx;
  logic [CW-1:0] wr_idx;

  // Status derives only from the stored count, so the handshake outputs never
  // depend combinationally on push_valid or pop_ready.
  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CW'(TOTAL_LAYERS));
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign count      = count_reg;

  assign push_fire = push_valid && !full;
  assign pop_fire  = pop_ready && !empty;
  assign top_idx   = count_reg - CW'(1);

  // A simultaneous push and pop replaces the top entry in place. Otherwise a
  // push lands in the first free slot. Flush suppresses the write entirely.
  assign wr_en  = push_fire && !flush;
  assign wr_idx = pop_fire ? top_idx : count_reg;

  assign top_layer = empty ? '0 : top_idx[TW-1:0];

  // Next occupancy: flush wins, then push-only grows, pop-only shrinks, and both together hold.
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else if (push_fire && !pop_fire) begin
      count_next = count_reg + CW'(1);
    end else if (pop_fire && !push_fire) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Sticky error flags: set on a rejected push or pop, cleared only by flush or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else if (flush) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      if (push_valid && full) ovf_reg <= 1'b1;
      if (pop_ready && empty) unf_reg <= 1'b1;
    end
  end

  assign err_overflow  = ovf_reg;
  assign err_underflow = unf_reg;

  // One storage slot per layer. The whole matrix is written at once, and a slot
  // keeps its contents after a pop.
  generate
    for (genvar gi = 0; gi < TOTAL_LAYERS; gi++) begin : g_slot
      // Slot write when this slot is the push target.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          mem_reg[gi] <= '0;
        end else if (wr_en && (wr_idx == CW'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  // Show-ahead read of the top slot. No slot matches when the count is zero, so the output is zero when empty.
  always_comb begin
    pop_data = '0;
    for (int i = 0; i < TOTAL_LAYERS; i++) begin
      if (count_reg == CW'(i + 1)) pop_data = mem_reg[i];
    end
  end

endmodule

// File: tb/tb_layer_activation_stack.sv
// Directed and random checks of layer_activation_stack with 2x2 byte matrices
// and a depth of three.
module tb_layer_activation_stack;

  localparam int M  = 2;
  localparam int N  = 2;
  localparam int TL = 3;
  localparam int DW = 8;

  logic        clk;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_data;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_data;
  logic        flush;
  logic [1:0]  count;
  logic [1:0]  top_layer;
  logic        full;
  logic        empty;
  logic        err_overflow;
  logic        err_underflow;

  int n_cmp;
  int n_err;

  localparam logic [31:0] A = 32'h11223344;
  localparam logic [31:0] B = 32'h55667788;
  localparam logic [31:0] C = 32'h99aabbcc;
  localparam logic [31:0] D = 32'hddeeff00;
  localparam logic [31:0] X = 32'hcafef00d;
  localparam logic [31:0] E = 32'h0badbeef;

  layer_activation_stack #(
    .M(M), .N(N), .TOTAL_LAYERS(TL), .DATA_W(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .push_valid(push_valid),
    .push_ready(push_ready),
    .push_data(push_data),
    .pop_valid(pop_valid),
    .pop_ready(pop_ready),
    .pop_data(pop_data),
    .flush(flush),
    .count(count),
    .top_layer(top_layer),
    .full(full),
    .empty(empty),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // One clock edge; outputs settle 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [31:0] d);
    push_valid = 1'b1;
    push_data  = d;
    step();
    push_valid = 1'b0;
  endtask

  task automatic do_pop();
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  logic [31:0] mdl[$];
  logic        pv;
  logic        pr;
  logic [31:0] rd;
  logic        push_ok;
  logic        pop_ok;

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b0;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    push_data  = '0;
    flush      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_push_ready", 32'(push_ready), 1);
    check("rst_pop_valid", 32'(pop_valid), 0);
    check("rst_top_layer", 32'(top_layer), 0);
    check("rst_pop_data", pop_data, 0);
    check("rst_errs", {30'd0, err_overflow, err_underflow}, 0);
    reset = 1'b1;

    // Fill the stack, then drain it in reverse order
    do_push(A);
    check("p1_pop_data", pop_data, A);
    check("p1_count", 32'(count), 1);
    check("p1_top", 32'(top_layer), 0);
    do_push(B);
    do_push(C);
    check("p3_full", 32'(full), 1);
    check("p3_push_ready", 32'(push_ready), 0);
    check("p3_count", 32'(count), 3);
    check("p3_top", 32'(top_layer), 2);
    check("pop1_data", pop_data, C);
    do_pop();
    check("pop2_data", pop_data, B);
    check("pop2_top", 32'(top_layer), 1);
    do_pop();
    check("pop3_data", pop_data, A);
    do_pop();
    check("drained_empty", 32'(empty), 1);
    check("drained_pop_data", pop_data, 0);

    // Overflow and underflow are sticky until flush
    do_push(A); do_push(B); do_push(C);
    do_push(D);
    check("ovf_flag", 32'(err_overflow), 1);
    check("ovf_count", 32'(count), 3);
    check("ovf_top_data", pop_data, C);
    do_pop();
    check("ovf_pop_b", pop_data, B);
    do_pop();
    check("ovf_pop_a", pop_data, A);
    do_pop();
    do_pop();
    check("unf_flag", 32'(err_underflow), 1);
    check("ovf_still_set", 32'(err_overflow), 1);
    check("unf_count", 32'(count), 0);
    do_flush();
    check("flush_errs", {30'd0, err_overflow, err_underflow}, 0);

    // A simultaneous push and pop replaces the top entry
    do_push(A); do_push(B);
    check("swap_popped", pop_data, B);
    push_valid = 1'b1; push_data = X; pop_ready = 1'b1;
    step();
    push_valid = 1'b0; pop_ready = 1'b0;
    check("swap_count", 32'(count), 2);
    check("swap_top_x", pop_data, X);
    do_pop();
    check("swap_then_a", pop_data, A);
    do_pop();
    check("swap_empty", 32'(empty), 1);

    // Flush overrides a push in the same cycle
    do_push(A); do_push(B);
    flush = 1'b1; push_valid = 1'b1; push_data = X;
    step();
    flush = 1'b0; push_valid = 1'b0;
    check("fl_count", 32'(count), 0);
    check("fl_empty", 32'(empty), 1);
    check("fl_pop_data", pop_data, 0);

    // Reset asserted between clock edges clears the stack immediately
    do_push(A); do_push(B);
    do_pop(); do_pop(); do_pop();   // the third pop sets the underflow flag
    do_push(A); do_push(B);
    #2 reset = 1'b0;
    #1;
    check("ar_count", 32'(count), 0);
    check("ar_pop_data", pop_data, 0);
    check("ar_unf", 32'(err_underflow), 0);
    #2 reset = 1'b1;
    do_push(E);
    check("ar_push_e", pop_data, E);
    check("ar_count_e", 32'(count), 1);
    do_pop();
    check("ar_after_pop", 32'(empty), 1);

    // Random traffic against a reference LIFO model
    do_flush();
    mdl.delete();
    for (int i = 0; i < 150; i++) begin
      pv = 1'($urandom_range(0, 1));
      pr = 1'($urandom_range(0, 1));
      rd = $urandom;
      check("rnd_pop_data", pop_data, (mdl.size() == 0) ? 32'd0 : mdl[mdl.size() - 1]);
      check("rnd_count", 32'(count), 32'(mdl.size()));
      push_ok = pv && (mdl.size() < TL);
      pop_ok  = pr && (mdl.size() > 0);
      if (push_ok && pop_ok) mdl[mdl.size() - 1] = rd;
      else if (push_ok) mdl.push_back(rd);
      else if (pop_ok) void'(mdl.pop_back());
      push_valid = pv; pop_ready = pr; push_data = rd;
      step();
    end
    push_valid = 1'b0; pop_ready = 1'b0;
    check("rnd_final_count", 32'(count), 32'(mdl.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/layer_activation_stack.md
LAYER_ACTIVATION_STACK -- requirements
Module: layer_activation_stack

Interface
REQ-001 SHALL have parameter M, default 2, number of matrix rows.
REQ-002 SHALL have parameter N, default 1, number of matrix columns.
REQ-003 SHALL have parameter TOTAL_LAYERS, default 3, stack depth in matrices, one per forward layer.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port push_valid, input, 1 bit, forward pass offers a layer's activation matrix.
REQ-007 SHALL have port push_ready, output, 1 bit, stack can accept a push.
REQ-008 SHALL have port push_data, input, data_type[0:M-1][0:N-1], activation matrix to store.
REQ-009 SHALL have port pop_valid, output, 1 bit, top entry is available to the backward pass.
REQ-010 SHALL have port pop_ready, input, 1 bit, backward pass consumes the top entry.
REQ-011 SHALL have port pop_data, output, data_type[0:M-1][0:N-1], top-of-stack matrix.
REQ-012 SHALL have port flush, input, 1 bit, synchronous clear of the stack.
REQ-013 SHALL have port count, output, $clog2(TOTAL_LAYERS+1) bits, number of stored matrices.
REQ-014 SHALL have port top_layer, output, $clog2(TOTAL_LAYERS) bits, layer index of the top entry (count-1); 0 when empty.
REQ-015 SHALL have ports full and empty, outputs, 1 bit each.
REQ-016 SHALL have ports err_overflow and err_underflow, outputs, 1 bit each, sticky error flags.

Function
REQ-017 SHALL operate as a LIFO: matrices pushed in forward order (layer 0 first) are popped in reverse order (last layer first).
REQ-018 SHALL complete a push on a clock edge where push_valid and push_ready are both 1.
REQ-019 SHALL complete a pop on a clock edge where pop_valid and pop_ready are both 1.
REQ-020 SHALL drive push_ready = !full and pop_valid = !empty, with no combinational path from push_valid or pop_ready.
REQ-021 SHALL drive empty = (count==0) and full = (count==TOTAL_LAYERS).
REQ-022 SHALL present pop_data from registered storage with zero read latency (show-ahead); pop_data SHALL be all-zero when empty.
REQ-023 SHALL, on a push alone, write push_data to slot count and increment count by 1; that data appears on pop_data in the next cycle.
REQ-024 SHALL, on a pop alone, decrement count by 1; the storage slot is not cleared.
REQ-025 SHALL, on a simultaneous push and pop (only possible when not empty and not full), overwrite the top slot with push_data and leave count unchanged.
REQ-026 SHALL keep count within 0..TOTAL_LAYERS; count SHALL never wrap.
REQ-027 SHALL set err_overflow when push_valid=1 while full; the push is ignored.
REQ-028 SHALL set err_underflow when pop_ready=1 while empty; the pop is ignored.
REQ-029 SHALL hold err_overflow and err_underflow at 1 until flush or reset.
REQ-030 SHALL, on flush=1, set count to 0 and clear both error flags on that edge; flush overrides any push or pop in the same cycle.
REQ-031 SHALL, in each cycle, treat all M*N elements of a matrix as one atomic entry; no partial writes.

Reset
REQ-032 SHALL, while reset=0, asynchronously clear count, all storage, err_overflow and err_underflow; outputs SHALL then be push_ready=1, pop_valid=0, empty=1, full=0, top_layer=0, pop_data=0.
REQ-033 SHALL, if reset asserts mid-operation, discard all stored matrices; no push or pop completes on that edge.
REQ-034 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification
REQ-035 Push A, B, C (TOTAL_LAYERS=3) -> full=1, push_ready=0, count=3, top_layer=2; pops then return C, B, A; empty=1 after the third pop.
REQ-036 Push D while full, then pop while empty -> err_overflow=1, err_underflow=1, storage and count unchanged; flush -> both flags 0.
REQ-037 Push A, B, then simultaneous push X and pop -> popped value B, count stays 2, next pop returns X, then A.
REQ-038 Push A, B, then flush with push_valid=1 in the same cycle -> count=0, empty=1, pop_data=0; X not stored.
REQ-039 Push A, B, assert reset=0 between clock edges -> count=0 immediately, pop_data=0; after release, push E then pop returns E.
REQ-040 Random push/pop traffic (M=2, N=2) compared against a reference LIFO model -> pop_data matches and count stays within 0..3 for every cycle.
